// File: rtl/iob_cache_write_buffer_if.sv
// Handshake bundle between the cache front-end, the write buffer and the
// back-end memory port.
interface iob_cache_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  push_i;
  logic [ADDR_W-1:0]     push_addr_i;
  logic [DATA_W-1:0]     push_data_i;
  logic [DATA_W/8-1:0]   push_strb_i;
  logic                  mem_valid_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_wstrb_o;
  logic                  mem_ready_i;

  // Buffer side
  modport slave (
    input  push_i, push_addr_i, push_data_i, push_strb_i, mem_ready_i,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );

  // Front-end / back-end side
  modport master (
    output push_i, push_addr_i, push_data_i, push_strb_i, mem_ready_i,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/iob_cache_write_buffer.sv
// Circular write buffer between the cache control block and back-end memory.
// Head entry is presented combinationally; a dropped push sets a sticky flag.
module iob_cache_write_buffer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  iob_cache_write_buffer_if.slave wb,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH_W:0]     level_o,
  output logic                 overflow_o
);
  localparam int              DEPTH   = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W+1)'(DEPTH);

  logic [ADDR_W-1:0]   addr_mem [DEPTH];
  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [DATA_W/8-1:0] strb_mem [DEPTH];

  logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic               push_ok, pop_ok;

  assign full_o  = (level_o == DEPTH_L);
  assign empty_o = (level_o == '0);
  assign push_ok = wb.push_i & ~full_o;
  assign pop_ok  = ~empty_o & wb.mem_ready_i;

  assign wb.mem_valid_o = ~empty_o;
  assign wb.mem_addr_o  = addr_mem[rd_ptr];
  assign wb.mem_wdata_o = data_mem[rd_ptr];
  assign wb.mem_wstrb_o = strb_mem[rd_ptr];

  // Storage is not reset: its contents only matter behind a valid level.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= wb.push_addr_i;
      data_mem[wr_ptr] <= wb.push_data_i;
      strb_mem[wr_ptr] <= wb.push_strb_i;
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_o <= level_o + 1'b1;
        2'b01:   level_o <= level_o - 1'b1;
        default: level_o <= level_o;
      endcase
      if (wb.push_i && full_o) overflow_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// Directed bench for the write buffer at DEPTH=4, 32-bit address/data.
module tb_iob_cache_write_buffer;
  localparam int ADDR_W = 32, DATA_W = 32, DEPTH_W = 2;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             full_o, empty_o, overflow_o;
  logic [DEPTH_W:0] level_o;
  int               checks = 0;
  int               failures = 0;

  iob_cache_write_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

  iob_cache_write_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .wb(wb.slave),
    .full_o(full_o), .empty_o(empty_o), .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_push(input logic p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wb.push_i      = p;
    wb.push_addr_i = a;
    wb.push_data_i = d;
    wb.push_strb_i = s;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, 64'(empty_o), 64'd1);
    chk({tag, "_full"},  64'(full_o), 64'd0);
    chk({tag, "_level"}, 64'(level_o), 64'd0);
    chk({tag, "_valid"}, 64'(wb.mem_valid_o), 64'd0);
    chk({tag, "_ovf"},   64'(overflow_o), 64'd0);
  endtask

  initial begin
    set_push(1'b0, '0, '0, '0);
    wb.mem_ready_i = 1'b0;
    step(); step();
    reset_i = 1'b0;
    step();
    chk_idle("reset");

    // Fill with the back-end stalled; head must stay on the first entry.
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'h10 + 32'(i), 32'hA0 + 32'(i), 4'(1 << i));
      step();
      chk("fill_level", 64'(level_o), 64'(i + 1));
      chk("fill_head",  64'(wb.mem_addr_o), 64'h10);
      chk("fill_valid", 64'(wb.mem_valid_o), 64'd1);
    end
    chk("fill_full", 64'(full_o), 64'd1);
    set_push(1'b1, 32'h14, 32'hA4, 4'hF);
    step();
    chk("ovf_set",   64'(overflow_o), 64'd1);
    chk("ovf_level", 64'(level_o), 64'd4);
    chk("ovf_head",  64'(wb.mem_addr_o), 64'h10);

    // Drain in order, one entry per cycle.
    set_push(1'b0, '0, '0, '0);
    wb.mem_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(wb.mem_valid_o), 64'd1);
      chk("drain_data",  64'(wb.mem_wdata_o), 64'hA0 + 64'(i));
      chk("drain_strb",  64'(wb.mem_wstrb_o), 64'(1 << i));
      step();
    end
    chk("drain_empty", 64'(empty_o), 64'd1);
    chk("drain_valid0", 64'(wb.mem_valid_o), 64'd0);
    chk("drain_ovf",   64'(overflow_o), 64'd1);

    // Streaming: push and pop every cycle, pointers wrap past DEPTH.
    for (int k = 0; k < 10; k++) begin
      set_push(1'b1, 32'h20 + 32'(k), 32'hB0 + 32'(k), 4'hF);
      step();
      chk("stream_valid", 64'(wb.mem_valid_o), 64'd1);
      chk("stream_data",  64'(wb.mem_wdata_o), 64'hB0 + 64'(k));
      chk("stream_addr",  64'(wb.mem_addr_o), 64'h20 + 64'(k));
      chk("stream_level", 64'(level_o), 64'd1);
    end
    set_push(1'b0, '0, '0, '0);
    step();
    chk("stream_empty", 64'(empty_o), 64'd1);

    // Full buffer with push and ready together: push dropped, pop taken.
    wb.mem_ready_i = 1'b0;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk_idle("reset2");
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'h30 + 32'(i), 32'hC0 + 32'(i), 4'hF);
      step();
    end
    chk("full2", 64'(full_o), 64'd1);
    set_push(1'b1, 32'h34, 32'hC4, 4'hF);
    wb.mem_ready_i = 1'b1;
    step();
    set_push(1'b0, '0, '0, '0);
    wb.mem_ready_i = 1'b0;
    chk("fullpp_level", 64'(level_o), 64'd3);
    chk("fullpp_ovf",   64'(overflow_o), 64'd1);
    chk("fullpp_head",  64'(wb.mem_wdata_o), 64'hC1);
    chk("fullpp_full",  64'(full_o), 64'd0);

    // Asynchronous reset mid-cycle with three entries pending.
    #2 reset_i = 1'b1;
    #1;
    chk_idle("async_rst");
    #1 reset_i = 1'b0;
    set_push(1'b1, 32'h40, 32'hD0, 4'h3);
    step();
    set_push(1'b0, '0, '0, '0);
    chk("post_rst_valid", 64'(wb.mem_valid_o), 64'd1);
    chk("post_rst_data",  64'(wb.mem_wdata_o), 64'hD0);
    chk("post_rst_strb",  64'(wb.mem_wstrb_o), 64'h3);
    chk("post_rst_level", 64'(level_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
